// File: rtl/syn_bank_arbiter.sv
// syn_bank_arbiter
//   Shares the four synapse banks between NREQ fire-dispatch requesters.
//   index[11:10] of each 12-bit request selects a bank; every bank has its own
//   round-robin arbiter and a one-entry registered output stage, so up to four
//   transfers complete per cycle (one per bank).
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   enable                1 = new grants allowed; 0 = output stages only drain
//   req_vld  [NREQ]       per-requester valid
//   req_addr [NREQ*12]    requester i index at [12*i+11:12*i]
//   req_rdy  [NREQ]       per-requester ready (combinational)
//   syn_vld_b/addr_b/src_b  bank b output stage (registered), b = 0..3
//   syn_rdy_b             bank b consumer ready
//   idle                  no request pending and every output stage empty
//
// Optional feature: define SYN_ARB_STATS_EN to add stats_clr and the
// per-bank 16-bit saturating stall counters on stall_cnt[63:0].

// One bank: round-robin pick among requesters that target this bank,
// feeding a single registered output slot.
module syn_bank_slot #(
    parameter int NREQ  = 2,
    parameter int SRC_W = 1,
    parameter int BANK  = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NREQ-1:0]            req_vld,
    input  logic [NREQ-1:0][11:0]      req_addr,
    input  logic                       syn_rdy,
    output logic [NREQ-1:0]            grant,
    output logic                       syn_vld,
    output logic [9:0]                 syn_addr,
    output logic [SRC_W-1:0]           syn_src
`ifdef SYN_ARB_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [15:0]                stall_cnt
`endif
);
    logic [NREQ-1:0]  hit;
    logic             found;
    logic [SRC_W-1:0] win;
    logic [SRC_W-1:0] nxt_ptr;
    logic [9:0]       win_addr;
    logic [SRC_W-1:0] rr_ptr;
    logic             load;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NREQ; i++)
            hit[i] = req_vld[i] && (req_addr[i][11:10] == 2'(BANK));
    end

    // Scan rr_ptr, rr_ptr+1, ... (mod NREQ); first hit wins. The pointer
    // for the next grant is computed alongside so NREQ need not be a power of 2.
    always_comb begin
        int j;
        j        = 0;
        found    = 1'b0;
        win      = '0;
        nxt_ptr  = rr_ptr;
        win_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && hit[j]) begin
                found    = 1'b1;
                win      = SRC_W'(j);
                win_addr = req_addr[j][9:0];
                nxt_ptr  = (j == NREQ - 1) ? '0 : SRC_W'(j + 1);
            end
        end
    end

    // Slot may refill in the same cycle its current entry is taken.
    assign load = enable && (!syn_vld || syn_rdy);

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++)
            grant[i] = load && found && (win == SRC_W'(i));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            syn_vld  <= 1'b0;
            syn_addr <= '0;
            syn_src  <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            syn_vld <= found;
            if (found) begin
                syn_addr <= win_addr;
                syn_src  <= win;
                rr_ptr   <= nxt_ptr;
            end
        end else if (syn_vld && syn_rdy) begin
            // enable low: drain only, pointer frozen
            syn_vld <= 1'b0;
        end
    end

`ifdef SYN_ARB_STATS_EN
    // Stall = some requester for this bank was left waiting this cycle.
    logic stall;
    assign stall = |(hit & ~grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (stats_clr)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

module syn_bank_arbiter #(
    parameter int NREQ  = 2,
    parameter int SRC_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*12-1:0]   req_addr,
    output logic [NREQ-1:0]      req_rdy,
    output logic                 syn_vld_0,
    output logic [9:0]           syn_addr_0,
    output logic [SRC_W-1:0]     syn_src_0,
    input  logic                 syn_rdy_0,
    output logic                 syn_vld_1,
    output logic [9:0]           syn_addr_1,
    output logic [SRC_W-1:0]     syn_src_1,
    input  logic                 syn_rdy_1,
    output logic                 syn_vld_2,
    output logic [9:0]           syn_addr_2,
    output logic [SRC_W-1:0]     syn_src_2,
    input  logic                 syn_rdy_2,
    output logic                 syn_vld_3,
    output logic [9:0]           syn_addr_3,
    output logic [SRC_W-1:0]     syn_src_3,
    input  logic                 syn_rdy_3,
`ifdef SYN_ARB_STATS_EN
    input  logic                 stats_clr,
    output logic [63:0]          stall_cnt,
`endif
    output logic                 idle
);
    logic [NREQ-1:0][11:0]       addr_a;
    logic [3:0][NREQ-1:0]        bgrant;
    logic [3:0]                  bvld;
    logic [3:0][9:0]             baddr;
    logic [3:0][SRC_W-1:0]       bsrc;
    logic [3:0]                  brdy;

    assign addr_a = req_addr;
    assign brdy   = {syn_rdy_3, syn_rdy_2, syn_rdy_1, syn_rdy_0};

    for (genvar b = 0; b < 4; b++) begin : g_bank
        syn_bank_slot #(.NREQ(NREQ), .SRC_W(SRC_W), .BANK(b)) u_bank (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable),
            .req_vld  (req_vld),
            .req_addr (addr_a),
            .syn_rdy  (brdy[b]),
            .grant    (bgrant[b]),
            .syn_vld  (bvld[b]),
            .syn_addr (baddr[b]),
            .syn_src  (bsrc[b])
`ifdef SYN_ARB_STATS_EN
            ,
            .stats_clr(stats_clr),
            .stall_cnt(stall_cnt[16*b +: 16])
`endif
        );
    end

    // Each requester targets exactly one bank, so OR-ing grants is safe.
    // Ready is masked while reset is held.
    always_comb begin
        req_rdy = '0;
        for (int b = 0; b < 4; b++)
            req_rdy = req_rdy | bgrant[b];
        if (!reset) req_rdy = '0;
    end

    assign idle = !(|req_vld) && !(|bvld);

    assign syn_vld_0 = bvld[0];  assign syn_addr_0 = baddr[0];  assign syn_src_0 = bsrc[0];
    assign syn_vld_1 = bvld[1];  assign syn_addr_1 = baddr[1];  assign syn_src_1 = bsrc[1];
    assign syn_vld_2 = bvld[2];  assign syn_addr_2 = baddr[2];  assign syn_src_2 = bsrc[2];
    assign syn_vld_3 = bvld[3];  assign syn_addr_3 = baddr[3];  assign syn_src_3 = bsrc[3];
endmodule

// File: tb/tb_syn_bank_arbiter.sv
module tb_syn_bank_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [1:0]  req_vld = '0;
    logic [11:0] a0 = '0, a1 = '0;
    logic [1:0]  req_rdy;
    logic [3:0]  rdy = 4'hF;
    logic        idle;
    logic        syn_vld_0, syn_vld_1, syn_vld_2, syn_vld_3;
    logic [9:0]  syn_addr_0, syn_addr_1, syn_addr_2, syn_addr_3;
    logic [0:0]  syn_src_0, syn_src_1, syn_src_2, syn_src_3;
`ifdef SYN_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [63:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    syn_bank_arbiter #(.NREQ(2)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .req_vld(req_vld), .req_addr({a1, a0}), .req_rdy(req_rdy),
        .syn_vld_0(syn_vld_0), .syn_addr_0(syn_addr_0), .syn_src_0(syn_src_0), .syn_rdy_0(rdy[0]),
        .syn_vld_1(syn_vld_1), .syn_addr_1(syn_addr_1), .syn_src_1(syn_src_1), .syn_rdy_1(rdy[1]),
        .syn_vld_2(syn_vld_2), .syn_addr_2(syn_addr_2), .syn_src_2(syn_src_2), .syn_rdy_2(rdy[2]),
        .syn_vld_3(syn_vld_3), .syn_addr_3(syn_addr_3), .syn_src_3(syn_src_3), .syn_rdy_3(rdy[3]),
`ifdef SYN_ARB_STATS_EN
        .stats_clr(stats_clr), .stall_cnt(stall_cnt),
`endif
        .idle(idle)
    );

    logic [3:0]       act_v;
    logic [3:0][9:0]  act_a;
    logic [3:0]       act_s;
    assign act_v = {syn_vld_3, syn_vld_2, syn_vld_1, syn_vld_0};
    assign act_a = {syn_addr_3, syn_addr_2, syn_addr_1, syn_addr_0};
    assign act_s = {syn_src_3, syn_src_2, syn_src_1, syn_src_0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic            en;
        logic [1:0]      vld;
        logic [11:0]     a0, a1;
        logic [3:0]      rdy;
        logic [1:0]      e_rdy;
        logic            e_idle;
        logic [3:0]      e_v;
        logic [3:0][9:0] e_a;
        logic [3:0]      e_s;
    } vec_t;

    function automatic vec_t mk(logic en, logic [1:0] vld, logic [11:0] x0, logic [11:0] x1,
                                logic [3:0] r, logic [1:0] er, logic ei, logic [3:0] ev,
                                logic [9:0] ea3, logic [9:0] ea2, logic [9:0] ea1, logic [9:0] ea0,
                                logic [3:0] es);
        vec_t v;
        v.en = en; v.vld = vld; v.a0 = x0; v.a1 = x1; v.rdy = r;
        v.e_rdy = er; v.e_idle = ei; v.e_v = ev;
        v.e_a = {ea3, ea2, ea1, ea0}; v.e_s = es;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_async_vld", {28'd0, act_v}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t tbl[20];

    initial begin
        int p0, p1, g0, g1;
        //              en vld  a0      a1      rdy    rdy   idl v      a3     a2     a1     a0     src
        tbl[0]  = mk(1, 2'b11, 12'h005, 12'h405, 4'hF, 2'b11, 0, 4'b0011, 10'h0, 10'h0, 10'h005, 10'h005, 4'b0010);
        tbl[1]  = mk(1, 2'b11, 12'h800, 12'h801, 4'hF, 2'b01, 0, 4'b0100, 10'h0, 10'h000, 10'h0, 10'h0, 4'b0000);
        tbl[2]  = mk(1, 2'b11, 12'h802, 12'h801, 4'hF, 2'b10, 0, 4'b0100, 10'h0, 10'h001, 10'h0, 10'h0, 4'b0100);
        tbl[3]  = mk(1, 2'b11, 12'h802, 12'h803, 4'hF, 2'b01, 0, 4'b0100, 10'h0, 10'h002, 10'h0, 10'h0, 4'b0000);
        tbl[4]  = mk(1, 2'b00, 12'h000, 12'h000, 4'hF, 2'b00, 0, 4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[5]  = mk(1, 2'b00, 12'h000, 12'h000, 4'hF, 2'b00, 1, 4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[6]  = mk(1, 2'b01, 12'hC07, 12'h000, 4'h7, 2'b01, 0, 4'b1000, 10'h007, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[7]  = mk(1, 2'b01, 12'hC08, 12'h000, 4'h7, 2'b00, 0, 4'b1000, 10'h007, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[8]  = mk(1, 2'b01, 12'hC08, 12'h000, 4'h7, 2'b00, 0, 4'b1000, 10'h007, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[9]  = mk(1, 2'b01, 12'hC08, 12'h000, 4'h7, 2'b00, 0, 4'b1000, 10'h007, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[10] = mk(1, 2'b01, 12'hC08, 12'h000, 4'hF, 2'b01, 0, 4'b1000, 10'h008, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[11] = mk(1, 2'b00, 12'h000, 12'h000, 4'hF, 2'b00, 0, 4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[12] = mk(1, 2'b10, 12'h000, 12'h4AA, 4'hF, 2'b10, 0, 4'b0010, 10'h0, 10'h0, 10'h0AA, 10'h0, 4'b0010);
        tbl[13] = mk(0, 2'b10, 12'h000, 12'h4AB, 4'hF, 2'b00, 0, 4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[14] = mk(0, 2'b10, 12'h000, 12'h4AB, 4'hF, 2'b00, 0, 4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[15] = mk(1, 2'b11, 12'h4B0, 12'h4AB, 4'hF, 2'b01, 0, 4'b0010, 10'h0, 10'h0, 10'h0B0, 10'h0, 4'b0000);
        tbl[16] = mk(1, 2'b10, 12'h000, 12'h4AB, 4'hF, 2'b10, 0, 4'b0010, 10'h0, 10'h0, 10'h0AB, 10'h0, 4'b0010);
        tbl[17] = mk(0, 2'b00, 12'h000, 12'h000, 4'h0, 2'b00, 0, 4'b0010, 10'h0, 10'h0, 10'h0AB, 10'h0, 4'b0010);
        tbl[18] = mk(0, 2'b00, 12'h000, 12'h000, 4'hF, 2'b00, 0, 4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000);
        tbl[19] = mk(0, 2'b00, 12'h000, 12'h000, 4'hF, 2'b00, 1, 4'b0000, 10'h0, 10'h0, 10'h0, 10'h0, 4'b0000);

        // Reset held with both requesters valid: nothing granted, not idle.
        reset = 1'b0; enable = 1'b1; req_vld = 2'b11; a0 = 12'h005; a1 = 12'h405;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            chk("rst_req_rdy", {30'd0, req_rdy}, 32'h0);
            chk("rst_syn_vld", {28'd0, act_v}, 32'h0);
            chk("rst_idle", {31'd0, idle}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            enable = tbl[i].en; req_vld = tbl[i].vld; a0 = tbl[i].a0; a1 = tbl[i].a1; rdy = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_req_rdy", i), {30'd0, req_rdy}, {30'd0, tbl[i].e_rdy});
            chk($sformatf("v%0d_idle", i), {31'd0, idle}, {31'd0, tbl[i].e_idle});
            @(posedge clk); #1;
            chk($sformatf("v%0d_syn_vld", i), {28'd0, act_v}, {28'd0, tbl[i].e_v});
            for (int b = 0; b < 4; b++)
                if (tbl[i].e_v[b]) begin
                    chk($sformatf("v%0d_addr%0d", i, b), {22'd0, act_a[b]}, {22'd0, tbl[i].e_a[b]});
                    chk($sformatf("v%0d_src%0d", i, b), {31'd0, act_s[b]}, {31'd0, tbl[i].e_s[b]});
                end
            @(negedge clk);
        end

        // Contended stream on bank 2 from fresh pointers: strict alternation,
        // each requester advances only when granted.
        req_vld = 2'b00; enable = 1'b1; rdy = 4'hF;
        do_reset();
        p0 = 0; p1 = 0; g0 = 0; g1 = 0;
        for (int k = 0; k < 6; k++) begin
            req_vld = 2'b11; a0 = 12'h810 + 12'(p0); a1 = 12'h820 + 12'(p1);
            #1;
            chk($sformatf("cf%0d_req_rdy", k), {30'd0, req_rdy}, (k % 2) ? 32'h2 : 32'h1);
            if (req_rdy[0]) begin p0++; g0++; end
            if (req_rdy[1]) begin p1++; g1++; end
            @(posedge clk); #1;
            chk($sformatf("cf%0d_vld2", k), {31'd0, syn_vld_2}, 32'h1);
            chk($sformatf("cf%0d_src2", k), {31'd0, syn_src_2}, 32'(k % 2));
            chk($sformatf("cf%0d_addr2", k), {22'd0, syn_addr_2},
                (k % 2) ? 32'h20 + 32'(k / 2) : 32'h10 + 32'(k / 2));
            @(negedge clk);
        end
        chk("cf_grants0", 32'(g0), 32'd3);
        chk("cf_grants1", 32'(g1), 32'd3);
        req_vld = 2'b00;

`ifdef SYN_ARB_STATS_EN
        do_reset();
        chk("st_reset", {16'd0, stall_cnt[15:0]}, 32'h0);
        req_vld = 2'b11; a0 = 12'h001; a1 = 12'h002; enable = 1'b1; rdy = 4'hF;
        repeat (10) @(posedge clk);
        #1;
        chk("st_bank0_10", {16'd0, stall_cnt[15:0]}, 32'd10);
        chk("st_bank1_0", {16'd0, stall_cnt[31:16]}, 32'd0);
        @(negedge clk);
        req_vld = 2'b00; stats_clr = 1'b1;
        @(posedge clk); #1;
        chk("st_clr", {16'd0, stall_cnt[15:0]}, 32'd0);
        @(negedge clk);
        stats_clr = 1'b0; enable = 1'b0; req_vld = 2'b01; a0 = 12'h000;
        repeat (70000) @(posedge clk);
        #1;
        chk("st_sat", {16'd0, stall_cnt[15:0]}, 32'hFFFF);
        @(negedge clk);
        req_vld = 2'b00; enable = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
